motor_pwm_driver: RTL and testbench
===================================

# motor_pwm_driver

Downstream stage of the chassis direction controller. Consumes its 8-bit per-motor direction pin vector and produces the H-bridge drive pins. It applies a shared PWM duty and inserts a coast dead-time before any reversal, so no bridge leg sees a direct forward↔reverse transition. It also rejects illegal pin pairs and reports status to the PS.

## Interface
- PWM_BITS, 8: width of duty and PWM counter.
- PRESCALE, 4: clk cycles per PWM counter tick; ≥1.
- DEADTIME, 16: minimum coast clk cycles between opposite drive directions; ≥1.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dir_in  in  8  direction pins from the chassis controller; motor m uses pair {dir_in[2m+1], dir_in[2m]}; 01=forward, 10=reverse, 00=stop, 11=illegal.
- duty  in  PWM_BITS  requested duty.
- duty_valid  in  1  single-cycle strobe; loads duty into shadow register.
- pwm_out  out  8  H-bridge pins, same pair layout as dir_in.
- busy  out  1  high while any motor channel is in DEAD.
- fault  out  1  sticky; set when any pair reads 11; cleared only by rst.

## Operation
- Prescaler pcnt counts 0..PRESCALE-1; tick when pcnt==PRESCALE-1. PWM counter cnt advances on tick, wrapping 2^PWM_BITS-1→0.
- Period = PRESCALE·2^PWM_BITS clk cycles. pwm_on = (cnt < duty_active). duty 0 gives always off; max duty gives on for 2^PWM_BITS-1 of 2^PWM_BITS counts. 100% is not supported.
- duty_valid loads duty_shadow. duty_active ← duty_shadow on the tick where cnt wraps to 0, so a period never changes duty mid-way. When a strobe and a wrap coincide, the wrap uses the old shadow value.
- Per motor, an FSM holds cur (the 2-bit direction driven) and last (the last nonzero cur). Input pair p has 11 treated as 00 and sets fault.
  - IDLE: p≠00 → DRIVE, cur←p.
  - DRIVE: p==cur → stay. Any other p (00 or opposite) → DEAD, dcnt←DEADTIME-1, last←cur.
  - DEAD: dcnt decrements each cycle. If p==last → DRIVE immediately (same direction, safe). When dcnt==0: p==00 → IDLE; otherwise → DRIVE, cur←p.
- Pin pair = (state==DRIVE) ? cur & {2{pwm_on}} : 00. An output pair is never 11.
- busy = OR of (state==DEAD) across the 4 channels.

## Timing
- Reset values: pwm_out=0, busy=0, fault=0, all channels IDLE, cur=last=00, dcnt=0, pcnt=0, cnt=0, duty_shadow=duty_active=0.
- dir_in is sampled at edge N. Channel state updates at edge N. pwm_out and busy are registered and reflect the new state at edge N+1, giving 1 cycle of pin latency after the state.
- Reversal at edge N (DRIVE→DEAD): pins stay 00 for at least DEADTIME consecutive cycles. The opposite direction reaches the pins no earlier than edge N+DEADTIME+1.
- Stop followed by reverse within the dead window still waits for dcnt expiry. Stop then restore of the same direction resumes with no dead time.
- fault is set at edge N+1 after a sampled 11 and holds until rst.
- Reset asserted mid-DEAD or mid-period returns to the reset state at that edge. Pins are 00 from the next edge.
- The PWM phase is shared by all channels. Entering DRIVE does not restart cnt.

## Structure
- Package motor_pwm_pkg: channel state enum {IDLE, DRIVE, DEAD}; pair constants PAIR_STOP=2'b00, PAIR_FWD=2'b01, PAIR_REV=2'b10, PAIR_BAD=2'b11.
- Sub-module motor_channel (instantiated ×4): FSM, dcnt, and pin gating. It takes p, pwm_on, clk and rst, and outputs its pin pair, in_dead and bad.
- The top level owns the prescaler, the PWM counter, the duty registers, and the busy/fault reduction.

## Test plan
- Reset: hold rst 3 cycles with dir_in=8'h55 and duty_valid pulsed → pwm_out=0, busy=0, fault=0 during reset and for the first cycle after.
- Forward duty: PRESCALE=1, duty=128 loaded, dir_in=8'h55 → after the next wrap, each even pin is high 128 cycles and low 128 cycles per 256-cycle period; odd pins stay 0.
- Reversal: DEADTIME=16, driving 8'h55 with max duty, switch to 8'hAA at edge N → pwm_out=0 and busy=1 for cycles N+1..N+16; odd pins begin toggling at N+17; busy=0 from N+17.
- Stop-restore: drive 8'h55, set dir_in=0 for 5 cycles, return to 8'h55 → drive resumes 1 cycle after restore with no 16-cycle gap. Stop then 8'hAA after 5 cycles → first odd pin high no earlier than 17 cycles after the stop.
- Illegal pair: dir_in=8'h03 for 1 cycle, then 8'h01 → motor 0 pins 00 during the bad cycle, fault=1 thereafter and still 1 after 1000 cycles. Only rst clears it.
- Duty update: strobe duty=64 mid-period while duty_active=200 → the current period still shows 200 high counts; the next period shows 64.

Source files
------------

// File: rtl/motor_pwm_pkg.sv
// rtl/motor_pwm_pkg.sv - shared types and pin-pair constants for the motor PWM driver
package motor_pwm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DEAD  = 2'd2
   } ch_state_e;

   localparam logic [1:0] PAIR_STOP = 2'b00;
   localparam logic [1:0] PAIR_FWD  = 2'b01;
   localparam logic [1:0] PAIR_REV  = 2'b10;
   localparam logic [1:0] PAIR_BAD  = 2'b11;

   // An illegal pair is never driven; it behaves exactly like a stop request.
   function automatic logic [1:0] pair_clean(input logic [1:0] p);
      return (p == PAIR_BAD) ? PAIR_STOP : p;
   endfunction

endpackage

// File: rtl/motor_pwm_if.sv
// rtl/motor_pwm_if.sv - direction/duty inputs and bridge pin/status outputs
interface motor_pwm_if #(
   parameter int PWM_BITS = 8
);
   logic [7:0]          dir_in;
   logic [PWM_BITS-1:0] duty;
   logic                duty_valid;
   logic [7:0]          pwm_out;
   logic                busy;
   logic                fault;

   modport master (
      output dir_in, duty, duty_valid,
      input  pwm_out, busy, fault
   );

   modport slave (
      input  dir_in, duty, duty_valid,
      output pwm_out, busy, fault
   );
endinterface

// File: rtl/motor_channel.sv
// rtl/motor_channel.sv - one H-bridge channel: direction FSM, coast dead-time, pin gating
module motor_channel
   import motor_pwm_pkg::*;
#(
   parameter int DEADTIME = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] p,
   input  logic       pwm_on,
   output logic [1:0] pins,
   output logic       in_dead,
   output logic       bad
);
   localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

   ch_state_e     state_q, state_d;
   logic [1:0]    cur_q, cur_d;
   logic [1:0]    last_q, last_d;
   logic [1:0]    pins_q, pins_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          bad_q, bad_d;
   logic [1:0]    pc;

   // Next-state logic; pins are gated from the current state so they lag it by one cycle.
   always_comb begin
      pc      = pair_clean(p);
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      dcnt_d  = dcnt_q;
      bad_d   = (p == PAIR_BAD);
      pins_d  = (state_q == DRIVE) ? (cur_q & {2{pwm_on}}) : PAIR_STOP;
      case (state_q)
         IDLE: begin
            if (pc != PAIR_STOP) begin
               state_d = DRIVE;
               cur_d   = pc;
            end
         end
         DRIVE: begin
            if (pc != cur_q) begin
               state_d = DEAD;
               dcnt_d  = DW'(DEADTIME - 1);
               last_d  = cur_q;
            end
         end
         DEAD: begin
            // cur still holds last here, so resuming needs no reload.
            if (pc == last_q) begin
               state_d = DRIVE;
            end else if (dcnt_q == '0) begin
               if (pc == PAIR_STOP) begin
                  state_d = IDLE;
               end else begin
                  state_d = DRIVE;
                  cur_d   = pc;
               end
            end else begin
               dcnt_d = dcnt_q - DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Channel state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= PAIR_STOP;
         last_q  <= PAIR_STOP;
         pins_q  <= PAIR_STOP;
         dcnt_q  <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         pins_q  <= pins_d;
         dcnt_q  <= dcnt_d;
         bad_q   <= bad_d;
      end
   end

   assign pins    = pins_q;
   assign in_dead = (state_q == DEAD);
   assign bad     = bad_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - shared PWM timebase, duty registers and status for four bridge channels
module motor_pwm_driver
   import motor_pwm_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 4,
   parameter int DEADTIME = 16
) (
   input  logic       clk,
   input  logic       rst,
   motor_pwm_if.slave bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] shadow_q, shadow_d;
   logic [PWM_BITS-1:0] active_q, active_d;
   logic                busy_q, busy_d;
   logic                fault_q, fault_d;
   logic                tick, wrap, pwm_on;
   logic [7:0]          pins;
   logic [3:0]          dead_v, bad_v;

   assign pwm_on = (cnt_q < active_q);

   // Timebase and duty pipeline; active duty only changes at the period wrap.
   always_comb begin
      tick     = (pcnt_q == PW'(PRESCALE - 1));
      wrap     = tick && (cnt_q == '1);
      pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
      cnt_d    = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
      shadow_d = bus.duty_valid ? bus.duty : shadow_q;
      active_d = wrap ? shadow_q : active_q;
      busy_d   = |dead_v;
      fault_d  = fault_q | (|bad_v);
   end

   // Shared registers with synchronous reset; fault is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q   <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= '0;
         busy_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         busy_q   <= busy_d;
         fault_q  <= fault_d;
      end
   end

   for (genvar m = 0; m < 4; m++) begin : g_ch
      motor_channel #(
         .DEADTIME(DEADTIME)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .p      (bus.dir_in[2*m+1:2*m]),
         .pwm_on (pwm_on),
         .pins   (pins[2*m+1:2*m]),
         .in_dead(dead_v[m]),
         .bad    (bad_v[m])
      );
   end

   assign bus.pwm_out = pins;
   assign bus.busy    = busy_q;
   assign bus.fault   = fault_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed self-checking bench for motor_pwm_driver
module tb_motor_pwm_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   motor_pwm_if #(.PWM_BITS(8)) bus();

   motor_pwm_driver #(
      .PWM_BITS(8),
      .PRESCALE(1),
      .DEADTIME(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference timebase: counter, shadow and active duty as seen after each edge.
   logic [7:0] cnt_m  = 8'd0;
   logic [7:0] dact_m = 8'd0;
   logic [7:0] dsh_m  = 8'd0;
   logic       on_m   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      on_m = (cnt_m < dact_m);
      @(posedge clk);
      if (rst) begin
         cnt_m  = 8'd0;
         dact_m = 8'd0;
         dsh_m  = 8'd0;
      end else begin
         if (cnt_m == 8'hff) dact_m = dsh_m;
         if (bus.duty_valid) dsh_m = bus.duty;
         cnt_m = cnt_m + 8'd1;
      end
      #1;
   endtask

   task automatic wait_wrap();
      do step(); while (cnt_m != 8'd0);
   endtask

   int hi0, hi1, hi6, nz, nb;

   initial begin
      bus.dir_in     = 8'h55;
      bus.duty       = 8'd50;
      bus.duty_valid = 1'b0;
      rst            = 1'b1;

      // reset with inputs active
      for (int i = 0; i < 3; i++) begin
         bus.duty_valid = (i == 1);
         step();
         check("rst_pins", bus.pwm_out, 8'h00);
         check("rst_busy", bus.busy, 1'b0);
         check("rst_fault", bus.fault, 1'b0);
      end
      bus.duty_valid = 1'b0;
      rst = 1'b0;
      step();
      check("post_rst_pins", bus.pwm_out, 8'h00);
      check("post_rst_busy", bus.busy, 1'b0);
      check("post_rst_fault", bus.fault, 1'b0);

      // forward, 50% duty
      bus.duty = 8'd128;
      bus.duty_valid = 1'b1;
      step();
      bus.duty_valid = 1'b0;
      wait_wrap();
      hi0 = 0; hi1 = 0; hi6 = 0;
      for (int i = 1; i <= 256; i++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
         if (bus.pwm_out[1]) hi1++;
         if (bus.pwm_out[6]) hi6++;
         if (i == 1)   check("fwd_first_on", bus.pwm_out, 8'h55);
         if (i == 128) check("fwd_last_on", bus.pwm_out, 8'h55);
         if (i == 129) check("fwd_first_off", bus.pwm_out, 8'h00);
      end
      check("fwd_hi_pin0", hi0, 128);
      check("fwd_hi_pin6", hi6, 128);
      check("fwd_hi_pin1", hi1, 0);

      // reversal with max duty
      bus.duty = 8'd255;
      bus.duty_valid = 1'b1;
      step();
      bus.duty_valid = 1'b0;
      wait_wrap();
      repeat (10) step();
      check("rev_pre", bus.pwm_out, 8'h55);
      bus.dir_in = 8'hAA;
      step();
      check("rev_edge_pins", bus.pwm_out, 8'h55);
      nz = 0; nb = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (bus.pwm_out != 8'h00) nz++;
         if (!bus.busy) nb++;
      end
      check("rev_dead_pins", nz, 0);
      check("rev_dead_busy", nb, 0);
      step();
      check("rev_new_pins", bus.pwm_out, 8'hAA);
      check("rev_busy_clr", bus.busy, 1'b0);

      // back to forward, then stop and restore
      bus.dir_in = 8'h55;
      repeat (18) step();
      check("sr_pre", bus.pwm_out, 8'h55);
      bus.dir_in = 8'h00;
      repeat (5) step();
      check("sr_gap_pins", bus.pwm_out, 8'h00);
      check("sr_gap_busy", bus.busy, 1'b1);
      bus.dir_in = 8'h55;
      step();
      check("sr_restore_lat", bus.pwm_out, 8'h00);
      step();
      check("sr_resume_pins", bus.pwm_out, 8'h55);
      check("sr_resume_busy", bus.busy, 1'b0);

      // stop, then reverse inside the dead window
      bus.dir_in = 8'h00;
      step();
      nz = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 5) bus.dir_in = 8'hAA;
         step();
         if (bus.pwm_out != 8'h00) nz++;
      end
      check("sr_rev_gap", nz, 0);
      step();
      check("sr_rev_pins", bus.pwm_out, 8'hAA);

      // illegal pair
      bus.dir_in = 8'h00;
      repeat (20) step();
      check("bad_idle_pins", bus.pwm_out, 8'h00);
      check("bad_idle_busy", bus.busy, 1'b0);
      bus.dir_in = 8'h03;
      step();
      check("bad_cycle_pins", bus.pwm_out, 8'h00);
      check("bad_fault_lat", bus.fault, 1'b0);
      bus.dir_in = 8'h01;
      step();
      check("bad_fault_set", bus.fault, 1'b1);
      check("bad_next_pins", bus.pwm_out, 8'h00);
      step();
      check("bad_fwd_pins", bus.pwm_out, 8'h01);
      repeat (1000) step();
      check("bad_fault_sticky", bus.fault, 1'b1);

      // duty update mid-period, then a strobe coinciding with the wrap
      bus.duty = 8'd200;
      bus.duty_valid = 1'b1;
      step();
      bus.duty_valid = 1'b0;
      wait_wrap();
      hi0 = 0;
      for (int i = 1; i <= 256; i++) begin
         if (i == 100) begin
            bus.duty = 8'd64;
            bus.duty_valid = 1'b1;
         end
         step();
         bus.duty_valid = 1'b0;
         if (bus.pwm_out[0]) hi0++;
      end
      check("duty_old_period", hi0, 200);
      hi0 = 0;
      for (int i = 1; i <= 256; i++) begin
         if (i == 256) begin
            bus.duty = 8'd10;
            bus.duty_valid = 1'b1;
         end
         step();
         bus.duty_valid = 1'b0;
         if (bus.pwm_out[0]) hi0++;
      end
      check("duty_new_period", hi0, 64);
      hi0 = 0;
      for (int i = 1; i <= 256; i++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
      end
      check("duty_coincide_old", hi0, 64);
      hi0 = 0;
      for (int i = 1; i <= 256; i++) begin
         step();
         if (bus.pwm_out[0]) hi0++;
      end
      check("duty_coincide_new", hi0, 10);

      // reset in the middle of a dead window
      bus.dir_in = 8'h02;
      repeat (3) step();
      check("mid_dead_busy", bus.busy, 1'b1);
      rst = 1'b1;
      bus.dir_in = 8'h00;
      step();
      check("mid_rst_pins", bus.pwm_out, 8'h00);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_fault", bus.fault, 1'b0);
      rst = 1'b0;
      step();
      check("after_rst_pins", bus.pwm_out, 8'h00);
      check("after_rst_busy", bus.busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
